// File: rtl/rx_pkt_assembler.sv
// Builds fixed 256-word RX packets: 4 header words, payload from a round-robin selected
// channel FIFO (or the command FIFO), then zero padding, one word per cycle to the USB FIFO.
module rx_pkt_assembler #(
  parameter int         NUM_CHAN     = 2,
  parameter logic [4:0] CTRL_CHAN_ID = 5'h1F
) (
  input  logic              rxclk,
  input  logic              reset,
  input  logic [31:0]       adctime,
  input  logic [NUM_CHAN:0] chan_empty,
  input  logic [9:0]        chan_usedw,
  input  logic [15:0]       chan_fifodata,
  input  logic              have_space,
  input  logic [31:0]       rssi_0,
  input  logic [31:0]       rssi_1,
  input  logic [31:0]       rssi_2,
  input  logic [31:0]       rssi_3,
  input  logic [1:0]        underrun,
  output logic [3:0]        rd_select,
  output logic              chan_rdreq,
  output logic              WR,
  output logic [15:0]       fifodata,
  output logic [7:0]        debugbus
);

  localparam logic [8:0] PKT_WORDS = 9'd256;
  localparam logic [8:0] MAX_LEN   = 9'd252;
  localparam logic [3:0] CMD_IDX   = 4'(NUM_CHAN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEL     = 3'd1,
    HDR0    = 3'd2,
    HDR1    = 3'd3,
    TS0     = 3'd4,
    TS1     = 3'd5,
    PAYLOAD = 3'd6,
    PAD     = 3'd7
  } state_t;

  state_t      state_q;
  logic [3:0]  rdSelect_q;
  logic [3:0]  rrPtr_q;
  logic        rdreq_q;
  logic        wr_q;
  logic [15:0] data_q;
  logic [8:0]  wordCnt_q;
  logic [8:0]  rdCnt_q;
  logic [8:0]  payCnt_q;
  logic [8:0]  len_q;
  logic [31:0] ts_q;
  logic [15:0] hdr1_q;

  logic        hiValid, loValid;
  logic [3:0]  hiIdx, loIdx;
  logic        pickValid_d;
  logic [3:0]  pickIdx_d;
  logic [3:0]  rrNext_d;
  logic        isCmd_d;
  logic [8:0]  len_d;
  logic        accept_d;
  logic [31:0] rssiSel_d;
  logic [5:0]  rssi6_d;
  logic        urun_d;
  logic [4:0]  chanId_d;
  logic [15:0] hdr1_d;

  // Lowest eligible index at or above the RR pointer wins, otherwise wrap to the lowest overall.
  always_comb begin
    hiValid = 1'b0;
    hiIdx   = 4'd0;
    loValid = 1'b0;
    loIdx   = 4'd0;
    for (int i = NUM_CHAN; i >= 0; i--) begin
      if (!chan_empty[i]) begin
        loValid = 1'b1;
        loIdx   = 4'(i);
        if (4'(i) >= rrPtr_q) begin
          hiValid = 1'b1;
          hiIdx   = 4'(i);
        end
      end
    end
    pickValid_d = hiValid | loValid;
    pickIdx_d   = hiValid ? hiIdx : loIdx;
  end

  assign rrNext_d = (rdSelect_q >= CMD_IDX) ? 4'd0 : rdSelect_q + 4'd1;
  assign isCmd_d  = (rdSelect_q == CMD_IDX);
  assign len_d    = (chan_usedw >= 10'd252) ? MAX_LEN : chan_usedw[8:0];
  assign accept_d = isCmd_d ? (len_d != 9'd0) : (chan_usedw >= 10'd252);

  always_comb begin
    rssiSel_d = '0;
    if (!isCmd_d) begin
      case (rdSelect_q)
        4'd0:    rssiSel_d = rssi_0;
        4'd1:    rssiSel_d = rssi_1;
        4'd2:    rssiSel_d = rssi_2;
        4'd3:    rssiSel_d = rssi_3;
        default: rssiSel_d = '0;
      endcase
    end
  end

  assign rssi6_d  = (|rssiSel_d[31:6]) ? 6'h3F : rssiSel_d[5:0];
  assign urun_d   = (!isCmd_d && rdSelect_q < 4'd2) ? underrun[rdSelect_q[0]] : 1'b0;
  assign chanId_d = isCmd_d ? CTRL_CHAN_ID : {1'b0, rdSelect_q};
  assign hdr1_d   = {urun_d, 1'b0, rssi6_d, 3'd0, chanId_d};

  // Outputs are registered: state_q names the word currently presented on fifodata.
  always_ff @(posedge rxclk) begin
    if (reset) begin
      state_q    <= IDLE;
      rdSelect_q <= 4'd0;
      rrPtr_q    <= 4'd0;
      rdreq_q    <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= 16'd0;
      wordCnt_q  <= 9'd0;
      rdCnt_q    <= 9'd0;
      payCnt_q   <= 9'd0;
      len_q      <= 9'd0;
      ts_q       <= 32'd0;
      hdr1_q     <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_q    <= 1'b0;
          rdreq_q <= 1'b0;
          if (have_space && pickValid_d) begin
            rdSelect_q <= pickIdx_d;
            state_q    <= SEL;
          end
        end
        SEL: begin
          if (accept_d) begin
            len_q     <= len_d;
            ts_q      <= adctime;
            hdr1_q    <= hdr1_d;
            wr_q      <= 1'b1;
            data_q    <= {7'd0, len_d[7:0], 1'b0};
            wordCnt_q <= 9'd1;
            rdCnt_q   <= 9'd0;
            payCnt_q  <= 9'd0;
            state_q   <= HDR0;
          end else begin
            rrPtr_q <= rrNext_d;
            state_q <= IDLE;
          end
        end
        default: begin
          if (wordCnt_q == PKT_WORDS) begin
            wr_q    <= 1'b0;
            rdreq_q <= 1'b0;
            data_q  <= 16'd0;
            rrPtr_q <= rrNext_d;
            state_q <= IDLE;
          end else begin
            wordCnt_q <= wordCnt_q + 9'd1;
            // Reads start one cycle early so the FIFO latency is hidden behind TS0/TS1.
            rdreq_q <= (state_q != HDR0) && (rdCnt_q < len_q);
            if ((state_q != HDR0) && (rdCnt_q < len_q)) begin
              rdCnt_q <= rdCnt_q + 9'd1;
            end
            case (state_q)
              HDR0: begin
                data_q  <= hdr1_q;
                state_q <= HDR1;
              end
              HDR1: begin
                data_q  <= ts_q[15:0];
                state_q <= TS0;
              end
              TS0: begin
                data_q  <= ts_q[31:16];
                state_q <= TS1;
              end
              TS1: begin
                data_q   <= chan_fifodata;
                payCnt_q <= 9'd1;
                state_q  <= PAYLOAD;
              end
              PAYLOAD: begin
                if (payCnt_q < len_q) begin
                  data_q   <= chan_fifodata;
                  payCnt_q <= payCnt_q + 9'd1;
                end else begin
                  data_q  <= 16'd0;
                  state_q <= PAD;
                end
              end
              default: data_q <= 16'd0;
            endcase
          end
        end
      endcase
    end
  end

  assign rd_select  = rdSelect_q;
  assign chan_rdreq = rdreq_q;
  assign WR         = wr_q;
  assign fifodata   = data_q;
  assign debugbus   = {state_q, rdSelect_q, wr_q};

endmodule

// File: tb/tb_rx_pkt_assembler.sv
// Scoreboard bench for rx_pkt_assembler: stimulus pushes expected USB words into a queue,
// a monitor pops and compares every WR word; FIFO data is a pattern of {channel, read index}.
module tb_rx_pkt_assembler;

  localparam int NUM_CHAN = 2;

  logic              rxclk = 1'b0;
  logic              reset;
  logic [31:0]       adctime;
  logic [NUM_CHAN:0] chan_empty;
  logic [9:0]        chan_usedw;
  logic [15:0]       chan_fifodata = 16'd0;
  logic              have_space;
  logic [31:0]       rssi_0, rssi_1, rssi_2, rssi_3;
  logic [1:0]        underrun;
  logic [3:0]        rd_select;
  logic              chan_rdreq;
  logic              WR;
  logic [15:0]       fifodata;
  logic [7:0]        debugbus;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] expQ[$];
  int          expRunQ[$];
  int          wrCount[4] = '{0, 0, 0, 0};
  int          rdPtr[4]   = '{0, 0, 0, 0};
  int          modelPtr[4] = '{0, 0, 0, 0};
  int          rdreqTotal = 0;

  rx_pkt_assembler #(.NUM_CHAN(NUM_CHAN), .CTRL_CHAN_ID(5'h1F)) dut (
    .rxclk(rxclk), .reset(reset), .adctime(adctime), .chan_empty(chan_empty),
    .chan_usedw(chan_usedw), .chan_fifodata(chan_fifodata), .have_space(have_space),
    .rssi_0(rssi_0), .rssi_1(rssi_1), .rssi_2(rssi_2), .rssi_3(rssi_3),
    .underrun(underrun), .rd_select(rd_select), .chan_rdreq(chan_rdreq), .WR(WR),
    .fifodata(fifodata), .debugbus(debugbus)
  );

  always #5 rxclk = ~rxclk;

  // RX FIFO model with one cycle of read latency
  always @(posedge rxclk) begin
    if (chan_rdreq && rd_select <= 4'(NUM_CHAN)) begin
      chan_fifodata        <= {rd_select, 12'(rdPtr[rd_select[1:0]])};
      rdPtr[rd_select[1:0]] <= rdPtr[rd_select[1:0]] + 1;
    end
  end

  always_comb begin
    chan_usedw = '0;
    chan_empty = '0;
    if (rd_select <= 4'(NUM_CHAN)) chan_usedw = 10'(wrCount[rd_select[1:0]] - rdPtr[rd_select[1:0]]);
    for (int c = 0; c <= NUM_CHAN; c++) begin
      if (c == NUM_CHAN) chan_empty[c] = (wrCount[c] == rdPtr[c]);
      else               chan_empty[c] = ((wrCount[c] - rdPtr[c]) < 252);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int chan, input int words);
    wrCount[chan] = wrCount[chan] + words;
  endtask

  task automatic pushPacket(input int chan, input logic [15:0] hdr0, input logic [15:0] hdr1,
                            input logic [31:0] ts, input int len, input int nWords, input int consumed);
    logic [15:0] pkt[256];
    for (int i = 0; i < 256; i++) pkt[i] = 16'h0000;
    pkt[0] = hdr0;
    pkt[1] = hdr1;
    pkt[2] = ts[15:0];
    pkt[3] = ts[31:16];
    for (int i = 0; i < len; i++) pkt[4+i] = {4'(chan), 12'(modelPtr[chan] + i)};
    for (int i = 0; i < nWords; i++) expQ.push_back(pkt[i]);
    expRunQ.push_back(nWords);
    modelPtr[chan] = modelPtr[chan] + consumed;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while ((expQ.size() != 0 || WR || debugbus[7:5] != 3'd0) && n < maxCycles) begin
      @(negedge rxclk);
      n++;
    end
    if (n >= maxCycles) begin
      tests++;
      fails++;
      $display("[TB] FAIL waitIdle: timed out after %0d cycles with %0d words outstanding, required 0", n, expQ.size());
    end
    repeat (2) @(negedge rxclk);
  endtask

  // Monitor: every WR word is checked against the scoreboard, every burst against its length
  initial begin
    int          runLen = 0;
    logic        prevWr = 1'b0;
    logic [15:0] e;
    forever begin
      @(negedge rxclk);
      if (chan_rdreq) begin
        rdreqTotal++;
        checkOutput("rdSelectRange", 32'(rd_select <= 4'(NUM_CHAN)), 32'd1);
      end
      if (WR === 1'b1) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpectedWr: got word 0x%h, required no write", fifodata);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("word%0d", runLen), 32'(fifodata), 32'(e));
        end
        runLen++;
      end else if (prevWr) begin
        if (expRunQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL runLength: got burst of %0d words, required no burst", runLen);
        end else begin
          checkOutput("runLength", 32'(runLen), 32'(expRunQ.pop_front()));
        end
        runLen = 0;
      end
      prevWr = (WR === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   start;
    int   n;
    logic sawActivity;

    reset = 1'b1; have_space = 1'b0; adctime = 32'd0; underrun = 2'b00;
    rssi_0 = 32'd0; rssi_1 = 32'd0; rssi_2 = 32'd0; rssi_3 = 32'd0;
    repeat (3) @(negedge rxclk);
    checkOutput("resetWr",       32'(WR),         32'd0);
    checkOutput("resetRdreq",    32'(chan_rdreq), 32'd0);
    checkOutput("resetFifodata", 32'(fifodata),   32'd0);
    checkOutput("resetRdSelect", 32'(rd_select),  32'd0);
    checkOutput("resetDebugbus", 32'(debugbus),   32'd0);
    reset = 1'b0;

    // Test 1: full data packet from channel 0
    rssi_0 = 32'h15; adctime = 32'h12345678;
    start = rdreqTotal;
    pushPacket(0, 16'h01F8, 16'h1500, 32'h12345678, 252, 256, 252);
    applyStimulus(0, 300);
    have_space = 1'b1;
    waitIdle(600);
    checkOutput("t1Rdreq", 32'(rdreqTotal - start), 32'd252);

    // Test 2: short command packet, underrun ignored for the command FIFO
    underrun = 2'b11; adctime = 32'hCAFE0042;
    start = rdreqTotal;
    pushPacket(2, 16'h0014, 16'h001F, 32'hCAFE0042, 10, 256, 10);
    applyStimulus(2, 10);
    waitIdle(600);
    checkOutput("t2Rdreq", 32'(rdreqTotal - start), 32'd10);

    // Test 3 and 5: round robin over ch0, ch1, cmd; ch1 header carries saturated rssi and underrun
    underrun = 2'b10; rssi_1 = 32'h100; adctime = 32'h0BADF00D;
    start = rdreqTotal;
    pushPacket(0, 16'h01F8, 16'h1500, 32'h0BADF00D, 252, 256, 252);
    pushPacket(1, 16'h01F8, 16'hBF01, 32'h0BADF00D, 252, 256, 252);
    pushPacket(2, 16'h0006, 16'h001F, 32'h0BADF00D, 3,   256, 3);
    pushPacket(0, 16'h01F8, 16'h1500, 32'h0BADF00D, 252, 256, 252);
    pushPacket(1, 16'h01F8, 16'hBF01, 32'h0BADF00D, 252, 256, 252);
    applyStimulus(0, 504);
    applyStimulus(1, 504);
    applyStimulus(2, 3);
    waitIdle(2000);
    checkOutput("t3Rdreq", 32'(rdreqTotal - start), 32'd1011);

    // Test 4: data ready but no USB space
    have_space = 1'b0; adctime = 32'h00000001;
    start = rdreqTotal;
    applyStimulus(0, 252);
    sawActivity = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge rxclk);
      if (WR || chan_rdreq) sawActivity = 1'b1;
    end
    checkOutput("t4HeldOff", 32'(sawActivity), 32'd0);
    pushPacket(0, 16'h01F8, 16'h1500, 32'h00000001, 252, 256, 252);
    have_space = 1'b1;
    n = 0;
    while (!WR && n < 10) begin
      @(negedge rxclk);
      n++;
    end
    checkOutput("t4StartLatency", 32'(n <= 3), 32'd1);
    waitIdle(600);
    checkOutput("t4Rdreq", 32'(rdreqTotal - start), 32'd252);

    // Test 6: reset while payload word 100 is on the bus
    adctime = 32'hDEADBEEF;
    start = rdreqTotal;
    pushPacket(0, 16'h01F8, 16'h1500, 32'hDEADBEEF, 252, 105, 103);
    applyStimulus(0, 504);
    n = 0;
    while (!WR && n < 20) begin
      @(negedge rxclk);
      n++;
    end
    checkOutput("t6PacketStart", 32'(WR), 32'd1);
    repeat (104) @(negedge rxclk);
    reset = 1'b1;
    @(negedge rxclk);
    checkOutput("t6WrAfterReset",    32'(WR),            32'd0);
    checkOutput("t6RdreqAfterReset", 32'(chan_rdreq),    32'd0);
    checkOutput("t6StateAfterReset", 32'(debugbus[7:5]), 32'd0);
    reset = 1'b0;
    pushPacket(0, 16'h01F8, 16'h1500, 32'hDEADBEEF, 252, 256, 252);
    waitIdle(600);
    checkOutput("t6Rdreq", 32'(rdreqTotal - start), 32'd355);

    checkOutput("expQEmpty",    32'(expQ.size()),    32'd0);
    checkOutput("expRunQEmpty", 32'(expRunQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
